// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter with one-entry holding register
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
module uart_tx #(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200,
    parameter int STOP_BITS     = 1
) (
    input  logic       i_SysClock,
    input  logic       i_ResetN,
    input  logic       i_TxValid,
    input  logic [7:0] i_TxByte,
    output logic       o_TxReady,
    output logic       o_TxSerial,
    output logic       o_TxActive,
    output logic       o_TxDone
);

    localparam int MAX_CYCLE_CNT = ((SYS_CLOCK * 10 / UART_BAUDRATE + 5) / 10) - 1;
    localparam int CNT_W         = $clog2(MAX_CYCLE_CNT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CYCLE_CNT);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY_BIT = 3'd3,
`endif
        STOP_BIT   = 3'd4
    } tx_state_t;

    tx_state_t        state_q;
    logic [7:0]       hold_q;
    logic             hold_full_q;
    logic [7:0]       shift_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic             tx_serial_q;
    logic             tx_active_q;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    logic bit_end;
    logic load;

    assign bit_end = (cycle_cnt_q == CNT_MAX);
    // A held byte is picked up from IDLE or straight off the last stop bit, so frames abut.
    assign load = hold_full_q &&
                  ((state_q == IDLE) ||
                   ((state_q == STOP_BIT) && bit_end && (bit_cnt_q == LAST_STOP)));

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cycle_cnt_q <= '0;
            bit_cnt_q   <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            if (i_TxValid && !hold_full_q) begin
                hold_q      <= i_TxByte;
                hold_full_q <= 1'b1;
            end

            cycle_cnt_q <= bit_end ? '0 : cycle_cnt_q + CNT_W'(1);

            if (load) begin
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
                state_q     <= START_BIT;
                cycle_cnt_q <= '0;
                bit_cnt_q   <= '0;
                tx_serial_q <= 1'b0;
                tx_active_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
                parity_q    <= ^hold_q;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        cycle_cnt_q <= '0;
                        bit_cnt_q   <= '0;
                        tx_serial_q <= 1'b1;
                        tx_active_q <= 1'b0;
                    end
                    START_BIT: begin
                        if (bit_end) begin
                            state_q     <= DATA_BITS;
                            bit_cnt_q   <= '0;
                            tx_serial_q <= shift_q[0];
                        end
                    end
                    DATA_BITS: begin
                        if (bit_end) begin
                            shift_q <= shift_q >> 1;
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
                                state_q     <= PARITY_BIT;
                                tx_serial_q <= parity_q;
`else
                                state_q     <= STOP_BIT;
                                tx_serial_q <= 1'b1;
`endif
                            end else begin
                                bit_cnt_q   <= bit_cnt_q + 3'd1;
                                tx_serial_q <= shift_q[1];
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY_BIT: begin
                        if (bit_end) begin
                            state_q     <= STOP_BIT;
                            tx_serial_q <= 1'b1;
                        end
                    end
`endif
                    STOP_BIT: begin
                        if (bit_end) begin
                            if (bit_cnt_q == LAST_STOP) begin
                                state_q     <= IDLE;
                                bit_cnt_q   <= '0;
                                tx_active_q <= 1'b0;
                            end else begin
                                bit_cnt_q   <= bit_cnt_q + 3'd1;
                            end
                            tx_serial_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        cycle_cnt_q <= '0;
                        bit_cnt_q   <= '0;
                        tx_serial_q <= 1'b1;
                        tx_active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_TxReady  = !hold_full_q;
    assign o_TxSerial = tx_serial_q;
    assign o_TxActive = tx_active_q;
    assign o_TxDone   = (state_q == IDLE) && !hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (1 and 2 stop-bit instances)
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB1 = 10 + PAR;
    localparam int NB2 = 11 + PAR;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       v1 = 1'b0, v2 = 1'b0;
    logic [7:0] b1 = 8'h00, b2 = 8'h00;
    logic       r1, s1, a1, d1;
    logic       r2, s2, a2, d2;
    int         checks = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    uart_tx #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000), .STOP_BITS(1)) dut1 (
        .i_SysClock(clk), .i_ResetN(rstn), .i_TxValid(v1), .i_TxByte(b1),
        .o_TxReady(r1), .o_TxSerial(s1), .o_TxActive(a1), .o_TxDone(d1)
    );

    uart_tx #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000), .STOP_BITS(2)) dut2 (
        .i_SysClock(clk), .i_ResetN(rstn), .i_TxValid(v2), .i_TxByte(b2),
        .o_TxReady(r2), .o_TxSerial(s2), .o_TxActive(a2), .o_TxDone(d2)
    );

    // Line bits in transmit order (bit 0 = start); unused upper bits read as idle high.
    function automatic logic [11:0] frame(input logic [7:0] b);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic send(input int sel, input logic [7:0] b, input string name);
        logic rdy;
        @(negedge clk);
        if (sel == 1) begin v1 = 1'b1; b1 = b; end
        else          begin v2 = 1'b1; b2 = b; end
        @(posedge clk);
        #1;
        if (sel == 1) v1 = 1'b0; else v2 = 1'b0;
        rdy = (sel == 1) ? r1 : r2;
        checks++;
        if (rdy !== 1'b0) begin
            errs++;
            $display("FAIL %s handshake: o_TxReady=%b expected 0", name, rdy);
        end
    endtask

    task automatic expect_frame(input int sel, input logic [11:0] bits, input int nb,
                                input string name);
        logic s, a;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                s = (sel == 1) ? s1 : s2;
                a = (sel == 1) ? a1 : a2;
                checks++;
                if (s !== bits[i] || a !== 1'b1) begin
                    errs++;
                    if (errs < 20)
                        $display("FAIL %s bit %0d clk %0d: serial=%b active=%b expected serial=%b active=1",
                                 name, i, c, s, a, bits[i]);
                end
            end
        end
    endtask

    task automatic expect_idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if ({s1, a1, d1} !== 3'b101) begin
                errs++;
                if (errs < 20)
                    $display("FAIL %s clk %0d: serial/active/done=%b%b%b expected 101",
                             name, i, s1, a1, d1);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s1, r1, a1, d1} !== 4'b1101) begin
            errs++;
            $display("FAIL reset_dut1: serial/ready/active/done=%b%b%b%b expected 1101", s1, r1, a1, d1);
        end
        checks++;
        if ({s2, r2, a2, d2} !== 4'b1101) begin
            errs++;
            $display("FAIL reset_dut2: serial/ready/active/done=%b%b%b%b expected 1101", s2, r2, a2, d2);
        end
        rstn = 1'b1;
        expect_idle(5, "reset_release");
    endtask

    task automatic test_single();
        send(1, 8'h55, "single");
        checks++;
        if (s1 !== 1'b1 || d1 !== 1'b0) begin
            errs++;
            $display("FAIL single_pre_start: serial=%b done=%b expected serial=1 done=0", s1, d1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (r1 !== 1'b1) begin
            errs++;
            $display("FAIL single_ready_rerise: o_TxReady=%b expected 1", r1);
        end
        expect_frame(1, frame(8'h55), NB1, "single_55");
        @(posedge clk);
        #1;
        checks++;
        if ({s1, a1, d1} !== 3'b101) begin
            errs++;
            $display("FAIL single_end: serial/active/done=%b%b%b expected 101", s1, a1, d1);
        end
        expect_idle(10, "single_idle");
    endtask

    task automatic test_back_to_back();
        send(1, 8'hA5, "b2b_first");
        @(posedge clk);
        fork
            begin
                expect_frame(1, frame(8'hA5), NB1, "b2b_a5");
                expect_frame(1, frame(8'h3C), NB1, "b2b_3c");
            end
            begin
                repeat (30) @(negedge clk);
                send(1, 8'h3C, "b2b_second");
                repeat (70 + 10 * PAR) @(posedge clk);
                #1;
                checks++;
                if (r1 !== 1'b1 || a1 !== 1'b1) begin
                    errs++;
                    $display("FAIL b2b_reload: ready=%b active=%b expected 1 1", r1, a1);
                end
            end
        join
        @(posedge clk);
        #1;
        checks++;
        if (d1 !== 1'b1) begin
            errs++;
            $display("FAIL b2b_done: o_TxDone=%b expected 1", d1);
        end
    endtask

    task automatic test_ignore_while_full();
        send(1, 8'h11, "ign_first");
        @(posedge clk);
        fork
            begin
                expect_frame(1, frame(8'h11), NB1, "ign_11");
                expect_frame(1, frame(8'h22), NB1, "ign_22");
            end
            begin
                @(negedge clk);
                v1 = 1'b1;
                b1 = 8'h22;
                @(posedge clk);
                #1;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    b1 = (i % 2 == 0) ? 8'hFF : 8'h00;
                end
                checks++;
                if (r1 !== 1'b0) begin
                    errs++;
                    $display("FAIL ign_ready: o_TxReady=%b expected 0", r1);
                end
                @(negedge clk);
                v1 = 1'b0;
            end
        join
        expect_idle(30, "ign_no_extra");
    endtask

    task automatic test_stop2();
        send(2, 8'hFF, "stop2_first");
        @(posedge clk);
        fork
            begin
                expect_frame(2, frame(8'hFF), NB2, "stop2_ff");
                expect_frame(2, frame(8'h00), NB2, "stop2_next");
            end
            send(2, 8'h00, "stop2_second");
        join
        @(posedge clk);
        #1;
        checks++;
        if ({s2, a2, d2} !== 3'b101) begin
            errs++;
            $display("FAIL stop2_end: serial/active/done=%b%b%b expected 101", s2, a2, d2);
        end
    endtask

    task automatic test_reset_mid_frame();
        send(1, 8'h00, "rst_first");
        repeat (5) @(posedge clk);
        send(1, 8'hF0, "rst_hold");
        repeat (30) @(negedge clk);
        checks++;
        if (s1 !== 1'b0 || a1 !== 1'b1) begin
            errs++;
            $display("FAIL rst_pre: serial=%b active=%b expected 0 1", s1, a1);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({s1, r1, a1, d1} !== 4'b1101) begin
            errs++;
            $display("FAIL rst_async: serial/ready/active/done=%b%b%b%b expected 1101", s1, r1, a1, d1);
        end
        @(negedge clk);
        rstn = 1'b1;
        expect_idle(150, "rst_no_frame");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        send(1, 8'h07, "par_07");
        @(posedge clk);
        expect_frame(1, 12'b1_1_1_00000111_0, 11, "par_07");
        expect_idle(5, "par_07_end");
        send(1, 8'h03, "par_03");
        @(posedge clk);
        expect_frame(1, 12'b1_1_0_00000011_0, 11, "par_03");
        expect_idle(5, "par_03_end");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_while_full();
        test_stop2();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
